rv32i_exec_ctrl: RTL and testbench

Execution-and-control slice of the single-cycle RV32I core. It decodes the fetched instruction into datapath control, performs the ALU operation, and computes and registers the next program counter through the +4 and branch-target adders. It sits between instruction memory, register file and sign extender on one side and data memory and write-back mux on the other.

---
 rtl/rv32i_exec_ctrl.sv | 163 ++++++++++++++++
 tb/tb_rv32i_exec_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_exec_ctrl.sv
// Execution/control slice of a single-cycle RV32I core: decode, ALU, branch resolution, PC register.
// Optional macro ALU_SHIFT_EN enables the shifter; without it shift funct3 codes decode as NOP.
module rv32i_exec_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rd1,
    input  logic [DATA_WIDTH-1:0] rd2,
    input  logic [DATA_WIDTH-1:0] imm_op,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [1:0]            imm_src,
    output logic                  alu_src,
    output logic [DATA_WIDTH-1:0] alu_out,
    output logic                  eq,
    output logic                  reg_wr_en,
    output logic                  mem_wr_en,
    output logic                  result_src,
    output logic                  pc_src
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic                  funct7_5;
    logic                  shift_nop;
    logic                  reg_wr_dec;
    logic                  mem_wr_dec;
    logic                  is_branch;
    alu_ctrl_e             alu_ctrl;
    logic [DATA_WIDTH-1:0] operand2;
    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] pc_d;
    logic                  unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7_5     = instr[30];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

`ifdef ALU_SHIFT_EN
    assign shift_nop = 1'b0;
`else
    assign shift_nop = (funct3 == 3'b001) || (funct3 == 3'b101);
`endif

    // Main decoder; unknown opcodes fall through to an all-zero NOP doing an add.
    always_comb begin
        reg_wr_dec = 1'b0;
        mem_wr_dec = 1'b0;
        result_src = 1'b0;
        alu_src    = 1'b0;
        imm_src    = 2'b00;
        is_branch  = 1'b0;
        alu_ctrl   = ALU_ADD;
        case (opcode)
            OP_R, OP_I: begin
                if (!shift_nop) begin
                    reg_wr_dec = 1'b1;
                    alu_src    = (opcode == OP_I);
                    case (funct3)
                        3'b000:  alu_ctrl = (opcode == OP_R && funct7_5) ? ALU_SUB : ALU_ADD;
`ifdef ALU_SHIFT_EN
                        3'b001:  alu_ctrl = ALU_SLL;
                        3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
`endif
                        3'b010:  alu_ctrl = ALU_SLT;
                        3'b011:  alu_ctrl = ALU_SLTU;
                        3'b100:  alu_ctrl = ALU_XOR;
                        3'b110:  alu_ctrl = ALU_OR;
                        3'b111:  alu_ctrl = ALU_AND;
                        default: alu_ctrl = ALU_ADD;
                    endcase
                end
            end
            OP_LOAD: begin
                reg_wr_dec = 1'b1;
                result_src = 1'b1;
                alu_src    = 1'b1;
            end
            OP_STORE: begin
                mem_wr_dec = 1'b1;
                alu_src    = 1'b1;
                imm_src    = 2'b01;
            end
            OP_BRANCH: begin
                imm_src   = 2'b10;
                is_branch = 1'b1;
                alu_ctrl  = ALU_SUB;
            end
            default: ;
        endcase
    end

    assign operand2 = alu_src ? imm_op : rd2;

    always_comb begin
        case (alu_ctrl)
            ALU_ADD:  alu_out = rd1 + operand2;
            ALU_SUB:  alu_out = rd1 - operand2;
            ALU_AND:  alu_out = rd1 & operand2;
            ALU_OR:   alu_out = rd1 | operand2;
            ALU_XOR:  alu_out = rd1 ^ operand2;
`ifdef ALU_SHIFT_EN
            ALU_SLL:  alu_out = rd1 << operand2[4:0];
            ALU_SRL:  alu_out = rd1 >> operand2[4:0];
            ALU_SRA:  alu_out = $signed(rd1) >>> operand2[4:0];
`endif
            ALU_SLT:  alu_out = {{(DATA_WIDTH-1){1'b0}}, $signed(rd1) < $signed(operand2)};
            ALU_SLTU: alu_out = {{(DATA_WIDTH-1){1'b0}}, rd1 < operand2};
            default:  alu_out = rd1 + operand2;
        endcase
    end

    assign eq = (rd1 == operand2);

    always_comb begin
        pc_src = 1'b0;
        if (is_branch) begin
            case (funct3)
                3'b000:  pc_src = eq;
                3'b001:  pc_src = !eq;
                default: pc_src = 1'b0;
            endcase
        end
    end

    // Write enables are masked during reset; everything else stays purely combinational.
    assign reg_wr_en = reg_wr_dec & ~rst;
    assign mem_wr_en = mem_wr_dec & ~rst;

    assign pc_d = pc_src ? (pc_q + imm_op) : (pc_q + DATA_WIDTH'(4));
    assign pc   = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_rv32i_exec_ctrl.sv
// Self-checking bench for rv32i_exec_ctrl: directed vectors plus random instructions
// scored against a behavioural model through an expected-response queue.
module tb_rv32i_exec_ctrl;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  imm_src;
        logic        alu_src;
        logic [31:0] alu_out;
        logic        eq;
        logic        reg_wr_en;
        logic        mem_wr_en;
        logic        result_src;
        logic        pc_src;
        logic [31:0] next_pc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] instr, rd1, rd2, imm_op;
    logic [31:0] pc, alu_out;
    logic [1:0]  imm_src;
    logic        alu_src, eq, reg_wr_en, mem_wr_en, result_src, pc_src;

    exp_t        exp_q[$];
    logic [31:0] model_pc;
    int          n_checks;
    int          n_pass;

    rv32i_exec_ctrl #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .instr(instr), .rd1(rd1), .rd2(rd2), .imm_op(imm_op),
        .pc(pc), .imm_src(imm_src), .alu_src(alu_src), .alu_out(alu_out), .eq(eq),
        .reg_wr_en(reg_wr_en), .mem_wr_en(mem_wr_en), .result_src(result_src), .pc_src(pc_src)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        return {1'b0, f7, 15'd0, f3, 5'd0, op};
    endfunction

    // Behavioural reference: instruction semantics straight from the ISA rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] imm, input logic [31:0] cur_pc, input logic r);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        shifts_ok;
        logic        alu_insn;
        logic        taken;
        logic [31:0] y;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[30];
`ifdef ALU_SHIFT_EN
        shifts_ok = 1'b1;
`else
        shifts_ok = 1'b0;
`endif
        alu_insn = (op == OP_R || op == OP_I) && (shifts_ok || !(f3 == 3'd1 || f3 == 3'd5));
        e = '0;
        e.pc = cur_pc;
        if (alu_insn) begin
            e.reg_wr_en = 1'b1;
            e.alu_src   = (op == OP_I);
        end else if (op == OP_LOAD) begin
            e.reg_wr_en = 1'b1; e.result_src = 1'b1; e.alu_src = 1'b1;
        end else if (op == OP_STORE) begin
            e.mem_wr_en = 1'b1; e.alu_src = 1'b1; e.imm_src = 2'b01;
        end else if (op == OP_BRANCH) begin
            e.imm_src = 2'b10;
        end
        y = e.alu_src ? imm : b;
        if (alu_insn) begin
            case (f3)
                3'd0: e.alu_out = (op == OP_R && f7) ? a - y : a + y;
                3'd1: e.alu_out = a << y[4:0];
                3'd2: e.alu_out = ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
                3'd3: e.alu_out = (a < y) ? 32'd1 : 32'd0;
                3'd4: e.alu_out = a ^ y;
                3'd5: e.alu_out = f7 ? 32'($signed(a) >>> y[4:0]) : a >> y[4:0];
                3'd6: e.alu_out = a | y;
                default: e.alu_out = a & y;
            endcase
        end else if (op == OP_BRANCH) begin
            e.alu_out = a - y;
        end else begin
            e.alu_out = a + y;
        end
        e.eq  = (a == y);
        taken = (op == OP_BRANCH) && ((f3 == 3'd0 && e.eq) || (f3 == 3'd1 && !e.eq));
        e.pc_src = taken;
        if (r) begin
            e.reg_wr_en = 1'b0;
            e.mem_wr_en = 1'b0;
            e.next_pc   = 32'h0000_0000;
        end else begin
            e.next_pc = taken ? cur_pc + imm : cur_pc + 32'd4;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        else n_pass++;
    endtask

    // driver: apply one instruction per cycle, shortly after the rising edge
    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        instr = ins; rd1 = a; rd2 = b; imm_op = imm; rst = r;
        e = model(ins, a, b, imm, model_pc, r);
        exp_q.push_back(e);
        model_pc = e.next_pc;
    endtask

    // monitor: compare every presented cycle against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_pc",         pc,                 e.pc);
            check("sb_imm_src",    {30'd0, imm_src},   {30'd0, e.imm_src});
            check("sb_alu_src",    {31'd0, alu_src},   {31'd0, e.alu_src});
            check("sb_alu_out",    alu_out,            e.alu_out);
            check("sb_eq",         {31'd0, eq},        {31'd0, e.eq});
            check("sb_reg_wr_en",  {31'd0, reg_wr_en}, {31'd0, e.reg_wr_en});
            check("sb_mem_wr_en",  {31'd0, mem_wr_en}, {31'd0, e.mem_wr_en});
            check("sb_result_src", {31'd0, result_src},{31'd0, e.result_src});
            check("sb_pc_src",     {31'd0, pc_src},    {31'd0, e.pc_src});
        end
    end

    initial begin
        logic [6:0]  ops [6];
        logic [31:0] ins, a, b, imm;
        int          drain;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1; instr = NOP_INSTR; rd1 = '0; rd2 = '0; imm_op = '0;
        model_pc = 32'h0000_0000;
        @(posedge clk);

        // reset behaviour and PC sequencing
        drive(mk(OP_R, 3'd0, 1'b0), 32'd7, 32'd5, 32'd0, 1'b1);
        @(negedge clk); check("rst_reg_wr_forced", {31'd0, reg_wr_en}, 32'd0);
        check("rst_alu_comb", alu_out, 32'd12);
        drive(NOP_INSTR, 0, 0, 0, 1'b0);
        @(negedge clk); check("pc_after_reset", pc, 32'd0);
        drive(NOP_INSTR, 0, 0, 0, 1'b0);
        @(negedge clk); check("pc_plus4", pc, 32'd4);
        drive(mk(OP_BRANCH, 3'd1, 1'b0), 32'd3, 32'd3, 32'd16, 1'b0);
        @(negedge clk); check("bne_pc", pc, 32'd8);
        check("bne_pc_src", {31'd0, pc_src}, 32'd0);
        drive(NOP_INSTR, 0, 0, 0, 1'b0);
        @(negedge clk); check("bne_next_pc", pc, 32'd12);
        drive(mk(OP_BRANCH, 3'd0, 1'b0), 32'd3, 32'd3, 32'd16, 1'b1);
        @(negedge clk); check("rst_beq_pc_src", {31'd0, pc_src}, 32'd1);
        drive(NOP_INSTR, 0, 0, 0, 1'b0);
        @(negedge clk); check("rst_overrides_branch", pc, 32'd0);
        drive(NOP_INSTR, 0, 0, 0, 1'b0);
        drive(mk(OP_BRANCH, 3'd0, 1'b0), 32'd3, 32'd3, 32'd16, 1'b0);
        @(negedge clk); check("beq_pc", pc, 32'd8);
        check("beq_eq", {31'd0, eq}, 32'd1);
        check("beq_pc_src", {31'd0, pc_src}, 32'd1);

        // ALU and decode directed vectors
        drive(mk(OP_R, 3'd0, 1'b0), 32'd7, 32'd5, 32'd0, 1'b0);
        @(negedge clk); check("beq_next_pc", pc, 32'd24);
        check("add_7_5", alu_out, 32'd12);
        check("add_reg_wr", {31'd0, reg_wr_en}, 32'd1);
        drive(mk(OP_R, 3'd0, 1'b1), 32'd7, 32'd5, 32'd0, 1'b0);
        @(negedge clk); check("sub_7_5", alu_out, 32'd2);
        drive(mk(OP_R, 3'd0, 1'b1), 32'd0, 32'd1, 32'd0, 1'b0);
        @(negedge clk); check("sub_0_1", alu_out, 32'hFFFF_FFFF);
        drive(mk(OP_I, 3'd0, 1'b0), 32'd10, 32'd99, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk); check("addi", alu_out, 32'd7);
        check("addi_alu_src", {31'd0, alu_src}, 32'd1);
        drive(mk(OP_I, 3'd2, 1'b0), 32'h8000_0000, 32'd0, 32'd1, 1'b0);
        @(negedge clk); check("slti", alu_out, 32'd1);
        drive(mk(OP_I, 3'd3, 1'b0), 32'h8000_0000, 32'd0, 32'd1, 1'b0);
        @(negedge clk); check("sltiu", alu_out, 32'd0);
        drive(mk(OP_LOAD, 3'd2, 1'b0), 32'd100, 32'd0, 32'd8, 1'b0);
        @(negedge clk); check("lw_result_src", {31'd0, result_src}, 32'd1);
        check("lw_reg_wr", {31'd0, reg_wr_en}, 32'd1);
        check("lw_addr", alu_out, 32'd108);
        drive(mk(OP_STORE, 3'd2, 1'b0), 32'd100, 32'd55, 32'd4, 1'b0);
        @(negedge clk); check("sw_mem_wr", {31'd0, mem_wr_en}, 32'd1);
        check("sw_imm_src", {30'd0, imm_src}, 32'd1);
        check("sw_reg_wr", {31'd0, reg_wr_en}, 32'd0);
        drive(mk(OP_I, 3'd5, 1'b1), 32'h8000_0000, 32'd0, 32'h0000_0404, 1'b0);
        @(negedge clk);
`ifdef ALU_SHIFT_EN
        check("srai", alu_out, 32'hF800_0000);
        check("srai_reg_wr", {31'd0, reg_wr_en}, 32'd1);
`else
        check("srai_nop_reg_wr", {31'd0, reg_wr_en}, 32'd0);
`endif

        // random stimulus
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, 7'd0};
        for (int n = 0; n < 500; n++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 5)];
            if (ins[6:0] == 7'd0) ins[6:0] = 7'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : $urandom;
            if ($urandom_range(0, 3) == 0) imm = a;
            drive(ins, a, b, imm, ($urandom_range(0, 24) == 0));
        end

        // drain the scoreboard with a bounded wait
        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
